interconnect_link_output_buffer: RTL and testbench



---
 rtl/interconnect_link_output_buffer.sv | 93 +++++++++
 tb/tb_interconnect_link_output_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/interconnect_link_output_buffer.sv
// Per-plane output FIFOs that drive the sender side of an interconnect link with req/ack handshaking.
// Define TIA_LINK_STALL_COUNTERS_EN to add the per-plane saturating stall_cycles counters.
module interconnect_link_output_buffer #(
   parameter int NUM_PLANES = 4,
   parameter int DEPTH      = 4,
   parameter int TAG_WIDTH  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                       clock,
   input  logic                                       reset_n,
   input  logic [NUM_PLANES-1:0]                      enq_valid,
   input  logic [NUM_PLANES*TAG_WIDTH-1:0]            enq_tag,
   input  logic [NUM_PLANES*DATA_WIDTH-1:0]           enq_data,
   output logic [NUM_PLANES-1:0]                      enq_ready,
   output logic [NUM_PLANES*($clog2(DEPTH)+1)-1:0]    occupancy,
   output logic [NUM_PLANES-1:0]                      reqs,
   output logic [NUM_PLANES*TAG_WIDTH-1:0]            tag_lines,
   output logic [NUM_PLANES*DATA_WIDTH-1:0]           data_lines,
   input  logic [NUM_PLANES-1:0]                      acks
`ifdef TIA_LINK_STALL_COUNTERS_EN
   ,
   output logic [NUM_PLANES*16-1:0]                   stall_cycles
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // Handshake: a packet moves on a rising edge where reqs[p] && acks[p];
   // the head stays on the lines until that edge, and acks is ignored while reqs is low.
   for (genvar p = 0; p < NUM_PLANES; p++) begin : g_plane
      logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
      logic [DATA_WIDTH-1:0] data_mem [DEPTH];
      logic [PW-1:0]         rd_ptr;
      logic [PW-1:0]         wr_ptr;
      logic [CW-1:0]         count;
      logic                  not_empty;
      logic                  not_full;
      logic                  do_push;
      logic                  do_pop;

      assign not_empty = (count != '0);
      assign not_full  = (count != FULL_COUNT);
      assign do_push   = enq_valid[p] && not_full;
      assign do_pop    = not_empty && acks[p];

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end

      // Storage needs no reset: the lines are gated to zero whenever count is zero.
      always_ff @(posedge clock) begin
         if (do_push) begin
            tag_mem[wr_ptr]  <= enq_tag[p*TAG_WIDTH +: TAG_WIDTH];
            data_mem[wr_ptr] <= enq_data[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      assign enq_ready[p]                        = not_full;
      assign occupancy[p*CW +: CW]               = count;
      assign reqs[p]                             = not_empty;
      assign tag_lines[p*TAG_WIDTH +: TAG_WIDTH] = not_empty ? tag_mem[rd_ptr] : '0;
      assign data_lines[p*DATA_WIDTH +: DATA_WIDTH] = not_empty ? data_mem[rd_ptr] : '0;

`ifdef TIA_LINK_STALL_COUNTERS_EN
      logic [15:0] stall_q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            stall_q <= '0;
         end else if (not_empty && !acks[p] && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end

      assign stall_cycles[p*16 +: 16] = stall_q;
`endif
   end

endmodule

// File: tb/tb_interconnect_link_output_buffer.sv
// Randomized bench for interconnect_link_output_buffer: per-plane packet queues model the link,
// and a negedge monitor checks every plane's outputs against them.
module tb_interconnect_link_output_buffer;

   localparam int NUM_PLANES = 4;
   localparam int DEPTH      = 4;
   localparam int TAG_WIDTH  = 4;
   localparam int DATA_WIDTH = 32;
   localparam int CW         = $clog2(DEPTH) + 1;
   localparam int PKT_W      = TAG_WIDTH + DATA_WIDTH;

   logic                               clock;
   logic                               reset_n;
   logic [NUM_PLANES-1:0]              enq_valid;
   logic [NUM_PLANES*TAG_WIDTH-1:0]    enq_tag;
   logic [NUM_PLANES*DATA_WIDTH-1:0]   enq_data;
   logic [NUM_PLANES-1:0]              enq_ready;
   logic [NUM_PLANES*CW-1:0]           occupancy;
   logic [NUM_PLANES-1:0]              reqs;
   logic [NUM_PLANES*TAG_WIDTH-1:0]    tag_lines;
   logic [NUM_PLANES*DATA_WIDTH-1:0]   data_lines;
   logic [NUM_PLANES-1:0]              acks;
`ifdef TIA_LINK_STALL_COUNTERS_EN
   logic [NUM_PLANES*16-1:0]           stall_cycles;
`endif

   // Reference model: one packet queue {tag, data} and one stall count per plane.
   logic [PKT_W-1:0] exp_q [NUM_PLANES][$];
   int               model_stall [NUM_PLANES];

   int n_checks = 0;
   int n_fail   = 0;

   interconnect_link_output_buffer #(
      .NUM_PLANES (NUM_PLANES),
      .DEPTH      (DEPTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .enq_valid  (enq_valid),
      .enq_tag    (enq_tag),
      .enq_data   (enq_data),
      .enq_ready  (enq_ready),
      .occupancy  (occupancy),
      .reqs       (reqs),
      .tag_lines  (tag_lines),
      .data_lines (data_lines),
      .acks       (acks)
`ifdef TIA_LINK_STALL_COUNTERS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input int plane, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s plane %0d: got %0h expected %0h at %0t", name, plane, act, exp, $time);
      end
   endtask

   task automatic flush_model();
      for (int p = 0; p < NUM_PLANES; p++) begin
         exp_q[p].delete();
         model_stall[p] = 0;
      end
   endtask

   // ---------------- monitor ----------------
   // Inputs change just after posedge, so at negedge they already hold what the next edge will see.
   always @(negedge clock) begin
      if (reset_n) begin
         for (int p = 0; p < NUM_PLANES; p++) begin
            int sz;
            logic [PKT_W-1:0] head;
            sz   = exp_q[p].size();
            head = (sz != 0) ? exp_q[p][0] : '0;
            chk("occupancy", p, 64'(occupancy[p*CW +: CW]), 64'(sz));
            chk("enq_ready", p, 64'(enq_ready[p]), 64'(sz < DEPTH));
            chk("reqs", p, 64'(reqs[p]), 64'(sz != 0));
            chk("tag_lines", p, 64'(tag_lines[p*TAG_WIDTH +: TAG_WIDTH]), 64'(head[PKT_W-1 -: TAG_WIDTH]));
            chk("data_lines", p, 64'(data_lines[p*DATA_WIDTH +: DATA_WIDTH]), 64'(head[DATA_WIDTH-1:0]));
`ifdef TIA_LINK_STALL_COUNTERS_EN
            chk("stall_cycles", p, 64'(stall_cycles[p*16 +: 16]), 64'(model_stall[p]));
            if (sz != 0 && !acks[p] && model_stall[p] < 65535) model_stall[p]++;
`endif
            if (sz != 0 && acks[p]) void'(exp_q[p].pop_front());
            if (enq_valid[p] && sz < DEPTH)
               exp_q[p].push_back({enq_tag[p*TAG_WIDTH +: TAG_WIDTH], enq_data[p*DATA_WIDTH +: DATA_WIDTH]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      enq_valid = '0;
      enq_tag   = '0;
      enq_data  = '0;
      acks      = '0;
   endtask

   task automatic set_enq(input int p, input logic v, input logic [TAG_WIDTH-1:0] t, input logic [DATA_WIDTH-1:0] d);
      enq_valid[p]                        = v;
      enq_tag[p*TAG_WIDTH +: TAG_WIDTH]    = t;
      enq_data[p*DATA_WIDTH +: DATA_WIDTH] = d;
   endtask

   task automatic random_cycles(input int n, input int enq_pct, input int ack_pct);
      for (int c = 0; c < n; c++) begin
         for (int p = 0; p < NUM_PLANES; p++) begin
            set_enq(p, ($urandom_range(99) < enq_pct), TAG_WIDTH'($urandom), $urandom);
            acks[p] = ($urandom_range(99) < ack_pct);
         end
         tick();
      end
      idle_inputs();
   endtask

   // Asserts reset between edges and checks the outputs before the next edge arrives.
   task automatic async_reset_check();
      #2;
      reset_n = 1'b0;
      idle_inputs();
      flush_model();
      #1;
      for (int p = 0; p < NUM_PLANES; p++) begin
         chk("rst_reqs", p, 64'(reqs[p]), 64'd0);
         chk("rst_tag", p, 64'(tag_lines[p*TAG_WIDTH +: TAG_WIDTH]), 64'd0);
         chk("rst_data", p, 64'(data_lines[p*DATA_WIDTH +: DATA_WIDTH]), 64'd0);
         chk("rst_occupancy", p, 64'(occupancy[p*CW +: CW]), 64'd0);
         chk("rst_enq_ready", p, 64'(enq_ready[p]), 64'd1);
`ifdef TIA_LINK_STALL_COUNTERS_EN
         chk("rst_stall", p, 64'(stall_cycles[p*16 +: 16]), 64'd0);
`endif
      end
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      idle_inputs();
      flush_model();
      repeat (2) tick();
      reset_n = 1'b1;

      // Mid-operation reset.
      random_cycles(20, 70, 30);
      tick();
      async_reset_check();
      tick();

      // Single packet on plane 0, held for five stalled cycles, then acknowledged.
      set_enq(0, 1'b1, 4'd3, 32'hDEADBEEF);
      tick();
      set_enq(0, 1'b0, '0, '0);
      repeat (5) tick();
`ifdef TIA_LINK_STALL_COUNTERS_EN
      chk("stall_after_5", 0, 64'(stall_cycles[15:0]), 64'd5);
`endif
      acks[0] = 1'b1;
      tick();
      acks[0] = 1'b0;
      repeat (2) tick();

      // Plane 1 filled to DEPTH, a fifth write refused, then drained back to back.
      for (int i = 1; i <= DEPTH + 1; i++) begin
         set_enq(1, 1'b1, TAG_WIDTH'(i), 32'(i));
         tick();
      end
      set_enq(1, 1'b0, '0, '0);
      chk("full_occupancy", 1, 64'(occupancy[1*CW +: CW]), 64'(DEPTH));
      acks[1] = 1'b1;
      repeat (DEPTH + 1) tick();
      acks[1] = 1'b0;
      tick();

      // Plane 0: full with enq+ack (pop only), then enq+ack at occupancy 2.
      for (int i = 0; i < DEPTH; i++) begin
         set_enq(0, 1'b1, TAG_WIDTH'(i), 32'h100 + 32'(i));
         tick();
      end
      set_enq(0, 1'b1, 4'hA, 32'hAAAA_0000);
      acks[0] = 1'b1;
      tick();
      chk("full_enq_ack_occ", 0, 64'(occupancy[0 +: CW]), 64'(DEPTH - 1));
      set_enq(0, 1'b0, '0, '0);
      tick();
      set_enq(0, 1'b1, 4'hB, 32'hBBBB_0000);
      tick();
      chk("enq_ack_occ2", 0, 64'(occupancy[0 +: CW]), 64'd2);
      set_enq(0, 1'b0, '0, '0);
      repeat (3) tick();
      acks[0] = 1'b0;
      tick();

      // All planes, interleaved random traffic.
      random_cycles(1000, 55, 50);
      repeat (2) tick();
      random_cycles(200, 90, 20);
      acks = '1;
      repeat (DEPTH + 1) tick();
      acks = '0;

`ifdef TIA_LINK_STALL_COUNTERS_EN
      // Ack withheld long enough for the stall counter to saturate.
      async_reset_check();
      tick();
      set_enq(2, 1'b1, 4'h5, 32'h5555_AAAA);
      tick();
      set_enq(2, 1'b0, '0, '0);
      repeat (70000) tick();
      chk("stall_saturated", 2, 64'(stall_cycles[2*16 +: 16]), 64'hFFFF);
      acks[2] = 1'b1;
      tick();
      acks[2] = 1'b0;
      repeat (2) tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
